// File: rtl/multi_eq_pkg.sv
// Shared types for the multi-channel equality lock monitor.
//   lock_state_t : lock-detect FSM state encoding
//   STATE_W      : width of the exported state field
package multi_eq_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    HOLD   = 2'd3
  } lock_state_t;

endpackage

// File: rtl/eq_vec_compare.sv
// Combinational per-channel comparator: flags every channel that differs
// from channel 0.
//   in_data   [N*W] : channel i at [i*W +: W]
//   diff_mask [N]   : bit i = channel i != channel 0; bit 0 always 0
module eq_vec_compare #(
  parameter int W = 3,
  parameter int N = 3
) (
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   diff_mask
);

  always_comb begin
    // NOTE: assigning a default before any conditional/loop writes keeps
    // every bit driven on every path, so no latch is inferred.
    diff_mask = '0;
    for (int i = 1; i < N; i++) begin
      diff_mask[i] = (in_data[i*W +: W] != in_data[W-1:0]);
    end
  end

endmodule

// File: rtl/multi_eq_lock_monitor.sv
// N-channel, W-bit equality monitor with lock detection.
// Each accepted sample (in_valid & ~clear) is compared channel-by-channel
// against channel 0. LOCK_LEN consecutive all-equal samples acquire lock;
// LOSS_LEN consecutive mismatches drop it. Saturating match/mismatch
// counters and a sticky error flag provide status readout.
//   clk, rst_n    : clock, asynchronous active-low reset
//   clear         : synchronous clear of FSM, counters, sticky flag
//   in_valid      : in_data qualifier
//   in_data       : N channels of W bits
//   eq_valid      : registered copy of accepted in_valid
//   eq, diff_mask : compare result of last accepted sample
//   state, locked : FSM state; locked = LOCKED or HOLD
//   match_cnt     : accepted equal samples (saturating)
//   mismatch_cnt  : accepted unequal samples (saturating)
//   sticky_err    : mismatch seen while LOCKED or HOLD
module multi_eq_lock_monitor
  import multi_eq_pkg::*;
#(
  parameter int W        = 3,
  parameter int N        = 3,
  parameter int LOCK_LEN = 4,
  parameter int LOSS_LEN = 2,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [N*W-1:0]     in_data,
  output logic               eq_valid,
  output logic               eq,
  output logic [N-1:0]       diff_mask,
  output logic [STATE_W-1:0] state,
  output logic               locked,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [CNT_W-1:0]   mismatch_cnt,
  output logic               sticky_err
);

  localparam int MAX_LEN = (LOCK_LEN > LOSS_LEN) ? LOCK_LEN : LOSS_LEN;
  localparam int RUN_W   = $clog2(MAX_LEN) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [N-1:0] diff_now;
  logic         all_eq;
  logic         accept;

  lock_state_t  state_q, state_nxt;
  logic [RUN_W-1:0] run_q, run_nxt, run_inc;
  logic [RUN_W-1:0] miss_q, miss_nxt, miss_inc;
  logic         sticky_q, sticky_nxt;

  eq_vec_compare #(.W(W), .N(N)) u_cmp (
    .in_data   (in_data),
    .diff_mask (diff_now)
  );

  assign all_eq   = ~|diff_now;
  assign accept   = in_valid & ~clear;
  assign run_inc  = run_q + RUN_W'(1);
  assign miss_inc = miss_q + RUN_W'(1);

  // Next-state logic; clear wins over a same-cycle sample.
  always_comb begin
    state_nxt  = state_q;
    run_nxt    = run_q;
    miss_nxt   = miss_q;
    sticky_nxt = sticky_q;
    if (clear) begin
      state_nxt  = IDLE;
      run_nxt    = '0;
      miss_nxt   = '0;
      sticky_nxt = 1'b0;
    end else if (in_valid) begin
      unique case (state_q)
        IDLE: begin
          if (all_eq) begin
            state_nxt = ACQ;
            run_nxt   = RUN_W'(1);
          end
        end
        ACQ: begin
          if (!all_eq) begin
            state_nxt = IDLE;
            run_nxt   = '0;
          end else if (run_inc == RUN_W'(LOCK_LEN)) begin
            state_nxt = LOCKED;
            run_nxt   = '0;
          end else begin
            run_nxt = run_inc;
          end
        end
        LOCKED: begin
          if (!all_eq) begin
            sticky_nxt = 1'b1;
            if (LOSS_LEN == 1) begin
              // A single miss already drops lock; no miss count to carry.
              state_nxt = IDLE;
              miss_nxt  = '0;
            end else begin
              state_nxt = HOLD;
              miss_nxt  = RUN_W'(1);
            end
          end
        end
        HOLD: begin
          if (all_eq) begin
            state_nxt = LOCKED;
            miss_nxt  = '0;
          end else begin
            sticky_nxt = 1'b1;
            if (miss_inc == RUN_W'(LOSS_LEN)) begin
              state_nxt = IDLE;
              miss_nxt  = '0;
            end else begin
              miss_nxt = miss_inc;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      run_q    <= '0;
      miss_q   <= '0;
      sticky_q <= 1'b0;
      locked   <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      run_q    <= run_nxt;
      miss_q   <= miss_nxt;
      sticky_q <= sticky_nxt;
      locked   <= (state_nxt == LOCKED) || (state_nxt == HOLD);
    end
  end

  // Output/status registers. eq and diff_mask keep the last accepted
  // result across idle cycles and across clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq_valid     <= 1'b0;
      eq           <= 1'b0;
      diff_mask    <= '0;
      match_cnt    <= '0;
      mismatch_cnt <= '0;
    end else begin
      eq_valid <= accept;
      if (clear) begin
        match_cnt    <= '0;
        mismatch_cnt <= '0;
      end else if (in_valid) begin
        eq        <= all_eq;
        diff_mask <= diff_now;
        if (all_eq) begin
          if (match_cnt != CNT_MAX) match_cnt <= match_cnt + CNT_W'(1);
        end else begin
          if (mismatch_cnt != CNT_MAX) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign state      = state_q;
  assign sticky_err = sticky_q;

endmodule

// File: doc/multi_eq_lock_monitor.md
# multi_eq_lock_monitor

Parametrised N-channel, W-bit equality monitor with a lock-detect state machine. Each valid sample compares every channel against channel 0. Per-sample results are registered. A sequence of consecutive all-equal samples acquires lock, and a run of mismatches loses it. Saturating match/mismatch counters and a sticky error flag support status readout in the datapath-check layer.

## Interface
- `W`, 3, bits per channel (≥1)
- `N`, 3, channel count (≥2)
- `LOCK_LEN`, 4, consecutive equal samples needed to lock (≥2)
- `LOSS_LEN`, 2, consecutive mismatches needed to drop lock (≥1)
- `CNT_W`, 16, counter width
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `clear` in 1: synchronous clear of FSM, counters and sticky flag
- `in_valid` in 1: `in_data` qualifier
- `in_data` in N*W: channel i at `[i*W +: W]`
- `eq_valid` out 1: registered copy of accepted `in_valid`
- `eq` out 1: all channels equal for the last accepted sample
- `diff_mask` out N: bit i = channel i ≠ channel 0; bit 0 is always 0
- `state` out 2: FSM state
- `locked` out 1: state is LOCKED or HOLD
- `match_cnt` out CNT_W: accepted equal samples
- `mismatch_cnt` out CNT_W: accepted unequal samples
- `sticky_err` out 1: a mismatch occurred while LOCKED or HOLD

## Operation
- A sample is accepted when `in_valid`=1 and `clear`=0. `m` = all `diff_mask` bits are 0.
- FSM states: IDLE=0, ACQ=1, LOCKED=2, HOLD=3. Internal counter `run` tracks equal samples and `miss` tracks misses. Both have width `$clog2(max(LOCK_LEN,LOSS_LEN))+1`.
- **IDLE:**
  - Accepted with `m` → ACQ, `run`=1.
  - Mismatch → stay in IDLE.
- **ACQ:**
  - Accepted with `m` → `run`+1. When `run`+1 == `LOCK_LEN` → LOCKED, `run`=0.
  - Mismatch → IDLE, `run`=0.
- **LOCKED:**
  - Accepted with `m` → stay.
  - Mismatch → `miss`=1 and `sticky_err`=1. Next state is IDLE if `LOSS_LEN`==1, else HOLD.
- **HOLD:**
  - Accepted with `m` → LOCKED, `miss`=0.
  - Mismatch → `miss`+1 and `sticky_err`=1. When `miss`+1 == `LOSS_LEN` → IDLE, `miss`=0.
- No accepted sample: FSM, `run`, `miss` and counters hold. `eq_valid`=0. `eq` and `diff_mask` hold their last values.
- Counters increment by 1 per accepted sample and saturate at 2^CNT_W−1. They never wrap.
- `clear` forces the following, and has priority over a same-cycle `in_valid` (that sample is discarded):
  - state=IDLE
  - `run`=`miss`=0
  - both counters=0
  - `sticky_err`=0
  - `eq_valid`=0
- `sticky_err` clears only on `clear` or reset.

## Timing
- All outputs are registered. A sample accepted at edge k is reflected in `eq_valid`, `eq`, `diff_mask`, `state`, `locked` and both counters after edge k, so latency is 1 cycle.
- Back-to-back samples are accepted every cycle. There is no backpressure.
- Reset values: `eq_valid`=0, `eq`=0, `diff_mask`=0, `state`=IDLE, `locked`=0, `match_cnt`=0, `mismatch_cnt`=0, `sticky_err`=0.
- Reset asserted mid-acquisition or mid-HOLD: all state returns to reset values immediately. No partial `run`/`miss` survives.
- The lock transition is visible the same edge as the `LOCK_LEN`-th equal sample. Loss of lock is visible the same edge as the `LOSS_LEN`-th consecutive miss.

## Structure
- Package `multi_eq_pkg` contains:
  - the `lock_state_t` enum (IDLE/ACQ/LOCKED/HOLD with the encodings above)
  - a `STATE_W`=2 constant
- Sub-module `eq_vec_compare` is purely combinational, parametrised by `W` and `N`. It takes `in_data` and produces `diff_mask`.
- The top level holds the FSM, the `run`/`miss` counters, the saturating counters and the output registers.

## Test plan
All scenarios use the defaults W=3, N=3, LOCK_LEN=4, LOSS_LEN=2.
- **Reset value check:** reset, then idle with `in_valid`=0 → all outputs 0, `state`=0.
- **Lock acquisition:** 4 consecutive samples A=B=C=3'b101 → `state` goes 1,1,1,2; `locked`=1 after the 4th edge; `match_cnt`=4.
- **Mismatch during acquisition:** 2 equal samples, then A=5,B=5,C=4 → `diff_mask`=3'b100, `eq`=0, `state`=IDLE, `mismatch_cnt`=1.
- **Miss and recovery:** locked, then 1 mismatch → HOLD with `locked` still 1 and `sticky_err`=1. Next equal sample → LOCKED. Then 2 mismatches → IDLE, `locked`=0.
- **Clear and gaps:**
  - Assert `clear` together with `in_valid` and an equal sample → that sample is dropped; counters=0, `sticky_err`=0, `state`=IDLE.
  - Gaps with `in_valid`=0 during ACQ → `run` is preserved, and lock occurs after 4 accepted equal samples.
- **Saturation:** with CNT_W=3, send 10 equal samples → `match_cnt` stays at 7.
